// File: rtl/instruction_phase_sequencer.sv
// One-hot instruction phase sequencer with run/idle, stall,
// flush, multi-cycle execute hold and a retired-instruction counter.
module instruction_phase_sequencer #(
   parameter int PHASES     = 4,
   parameter int EXEC_PHASE = 2,
   parameter int CYC_W      = 4,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              stall,
   input  logic              flush,
   input  logic [CYC_W-1:0]  ext_cycles,
   output logic [PHASES-1:0] phase,
   output logic              fetch,
   output logic              decode,
   output logic              execute,
   output logic              commit,
   output logic              busy,
   output logic              instr_done,
   output logic [CNT_W-1:0]  instr_count
);

   localparam int P_W = (PHASES > 2) ? $clog2(PHASES) : 1;
   localparam logic [P_W-1:0] LP_EXEC = P_W'(EXEC_PHASE);
   localparam logic [P_W-1:0] LP_PRE  = P_W'(EXEC_PHASE - 1);
   localparam logic [P_W-1:0] LP_LAST = P_W'(PHASES - 1);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [P_W-1:0]     r_p;
   logic [P_W-1:0]     w_p_nxt;
   logic [CYC_W-1:0]   r_wait;
   logic [CYC_W-1:0]   w_wait_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [PHASES-1:0]  w_phase;
   logic               w_commit;

   // State, phase index, execute hold counter and retire counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_p     <= '0;
         r_wait  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_p     <= w_p_nxt;
         r_wait  <= w_wait_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: flush beats stall beats execute hold beats advance
   always_comb begin
      w_state_nxt = r_state;
      w_p_nxt     = r_p;
      w_wait_nxt  = r_wait;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (run) begin
               w_state_nxt = S_RUN;
               w_p_nxt     = '0;
               w_wait_nxt  = '0;
            end
         end
         S_RUN: begin
            if (flush) begin
               w_p_nxt    = '0;
               w_wait_nxt = '0;
               if (!run) w_state_nxt = S_IDLE;
            end else if (stall) begin
               w_p_nxt = r_p;
            end else if (r_p == LP_EXEC && r_wait != '0) begin
               w_wait_nxt = r_wait - CYC_W'(1);
            end else if (r_p != LP_LAST) begin
               w_p_nxt = r_p + P_W'(1);
               if (r_p == LP_PRE) w_wait_nxt = ext_cycles;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               w_p_nxt   = '0;
               if (!run) w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // One-hot phase decode; all-zero while idle
   always_comb begin
      w_phase = '0;
      for (int i = 0; i < PHASES; i++) begin
         w_phase[i] = (r_state == S_RUN) && (r_p == P_W'(i));
      end
   end

   assign w_commit    = w_phase[PHASES-1];
   assign phase       = w_phase;
   assign fetch       = w_phase[0];
   assign decode      = w_phase[1];
   assign execute     = w_phase[EXEC_PHASE];
   assign commit      = w_commit;
   assign busy        = |w_phase;
   assign instr_done  = w_commit & ~stall & ~flush;
   assign instr_count = r_cnt;

endmodule

// File: tb/tb_instruction_phase_sequencer.sv
// Scoreboard bench for instruction_phase_sequencer; a second
// instance with a 4-bit counter shares all inputs to show wrap.
module tb_instruction_phase_sequencer;

   typedef struct packed {
      logic       r;
      logic       s;
      logic       f;
      logic [3:0] x;
   } stim_t;

   typedef struct packed {
      logic [3:0] ph;
      logic       done;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        run;
   logic        stall;
   logic        flush;
   logic [3:0]  ext_cycles;
   logic [3:0]  phase;
   logic        fetch, decode, execute, commit, busy, instr_done;
   logic [15:0] instr_count;
   logic [3:0]  phase4;
   logic        fetch4, decode4, execute4, commit4, busy4, done4;
   logic [3:0]  count4;

   stim_t       stim_q[$];
   exp_t        exp_q[$];
   logic [15:0] exp_cnt;
   int          vectors;
   int          miscompares;

   instruction_phase_sequencer u_dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .stall       (stall),
      .flush       (flush),
      .ext_cycles  (ext_cycles),
      .phase       (phase),
      .fetch       (fetch),
      .decode      (decode),
      .execute     (execute),
      .commit      (commit),
      .busy        (busy),
      .instr_done  (instr_done),
      .instr_count (instr_count)
   );

   instruction_phase_sequencer #(.CNT_W(4)) u_dut4 (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .stall       (stall),
      .flush       (flush),
      .ext_cycles  (ext_cycles),
      .phase       (phase4),
      .fetch       (fetch4),
      .decode      (decode4),
      .execute     (execute4),
      .commit      (commit4),
      .busy        (busy4),
      .instr_done  (done4),
      .instr_count (count4)
   );

   logic [39:0] obs;
   assign obs = {phase, busy, instr_done, instr_count, count4,
                 fetch, decode, execute, commit,
                 phase4, busy4, done4,
                 fetch4, decode4, execute4, commit4};

   function automatic logic [39:0] mk(input exp_t e, input logic [15:0] c);
      return {e.ph, |e.ph, e.done, c, c[3:0],
              e.ph[0], e.ph[1], e.ph[2], e.ph[3],
              e.ph, |e.ph, e.done,
              e.ph[0], e.ph[1], e.ph[2], e.ph[3]};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Phase vector must be one-hot or zero at all times
   always @(negedge clk) begin
      vectors++;
      if (!$onehot0(phase) || !$onehot0(phase4)) begin
         miscompares++;
         $display("FAIL onehot phase=%b phase4=%b", phase, phase4);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic s, input logic f,
                      input logic [3:0] x, input logic [3:0] ph,
                      input logic d);
      stim_q.push_back('{r: r, s: s, f: f, x: x});
      exp_q.push_back('{ph: ph, done: d});
   endtask

   task automatic test_reset();
      reset = 1'b0;
      run = 1'b0; stall = 1'b0; flush = 1'b0; ext_cycles = 4'd0;
      exp_cnt = '0;
      #2;
      vectors++;
      if (obs !== 40'd0) begin
         miscompares++;
         $display("FAIL reset obs=%h want=0", obs);
      end
      tick();
      vectors++;
      if (obs !== 40'd0) begin
         miscompares++;
         $display("FAIL reset_edge obs=%h want=0", obs);
      end
      reset = 1'b1;
   endtask

   task automatic test_basic();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, 4'b0000, 0);
      for (int j = 0; j < 13; j++)
         add(1, 0, 0, 0, 4'(1 << (j % 4)), (j % 4) == 3);
      add(0, 0, 0, 0, 4'b0010, 0);
      add(0, 0, 0, 0, 4'b0100, 0);
      add(0, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0000, 0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         s = stim_q.pop_front();
         run = s.r; stall = s.s; flush = s.f; ext_cycles = s.x;
         #1;
         e = exp_q.pop_front();
         vectors++;
         if (obs !== mk(e, exp_cnt)) begin
            miscompares++;
            $display("FAIL basic row%0d got ph=%b done=%b cnt=%0d cnt4=%0d want ph=%b done=%b cnt=%0d",
                     k, phase, instr_done, instr_count, count4, e.ph, e.done, exp_cnt);
         end
         tick();
         if (e.done) exp_cnt++;
      end
   endtask

   task automatic test_exec_ext();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 7, 4'b0001, 0);
      add(1, 0, 0, 3, 4'b0010, 0);
      add(1, 0, 0, 9, 4'b0100, 0);
      add(1, 0, 0, 9, 4'b0100, 0);
      add(1, 0, 0, 9, 4'b0100, 0);
      add(1, 0, 0, 9, 4'b0100, 0);
      add(1, 0, 0, 9, 4'b1000, 1);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(1, 0, 0, 0, 4'b0010, 0);
      add(1, 0, 0, 5, 4'b0100, 0);
      add(0, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0000, 0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         s = stim_q.pop_front();
         run = s.r; stall = s.s; flush = s.f; ext_cycles = s.x;
         #1;
         e = exp_q.pop_front();
         vectors++;
         if (obs !== mk(e, exp_cnt)) begin
            miscompares++;
            $display("FAIL exec_ext row%0d got ph=%b done=%b cnt=%0d want ph=%b done=%b cnt=%0d",
                     k, phase, instr_done, instr_count, e.ph, e.done, exp_cnt);
         end
         tick();
         if (e.done) exp_cnt++;
      end
   endtask

   task automatic test_stall();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(1, 1, 0, 0, 4'b0010, 0);
      add(1, 1, 0, 0, 4'b0010, 0);
      add(1, 0, 0, 0, 4'b0010, 0);
      add(1, 0, 0, 0, 4'b0100, 0);
      add(1, 1, 0, 0, 4'b1000, 0);
      add(1, 1, 0, 0, 4'b1000, 0);
      add(1, 0, 0, 0, 4'b1000, 1);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(1, 0, 0, 2, 4'b0010, 0);
      add(1, 1, 0, 0, 4'b0100, 0);
      add(1, 0, 0, 0, 4'b0100, 0);
      add(1, 1, 0, 0, 4'b0100, 0);
      add(1, 0, 0, 0, 4'b0100, 0);
      add(1, 0, 0, 0, 4'b0100, 0);
      add(0, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0000, 0);
      add(1, 1, 0, 0, 4'b0000, 0);
      add(0, 0, 0, 0, 4'b0001, 0);
      add(0, 0, 0, 0, 4'b0010, 0);
      add(0, 0, 0, 0, 4'b0100, 0);
      add(0, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0000, 0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         s = stim_q.pop_front();
         run = s.r; stall = s.s; flush = s.f; ext_cycles = s.x;
         #1;
         e = exp_q.pop_front();
         vectors++;
         if (obs !== mk(e, exp_cnt)) begin
            miscompares++;
            $display("FAIL stall row%0d got ph=%b done=%b cnt=%0d want ph=%b done=%b cnt=%0d",
                     k, phase, instr_done, instr_count, e.ph, e.done, exp_cnt);
         end
         tick();
         if (e.done) exp_cnt++;
      end
   endtask

   task automatic test_flush();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(1, 0, 0, 2, 4'b0010, 0);
      add(1, 0, 1, 0, 4'b0100, 0);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(1, 0, 0, 0, 4'b0010, 0);
      add(1, 0, 0, 0, 4'b0100, 0);
      add(1, 1, 1, 0, 4'b1000, 0);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(1, 0, 0, 0, 4'b0010, 0);
      add(1, 0, 0, 0, 4'b0100, 0);
      add(1, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0001, 0);
      add(0, 0, 1, 0, 4'b0010, 0);
      add(0, 0, 0, 0, 4'b0000, 0);
      add(0, 0, 1, 0, 4'b0000, 0);
      add(1, 0, 1, 0, 4'b0000, 0);
      add(0, 0, 0, 0, 4'b0001, 0);
      add(0, 0, 0, 0, 4'b0010, 0);
      add(0, 0, 0, 0, 4'b0100, 0);
      add(0, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0000, 0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         s = stim_q.pop_front();
         run = s.r; stall = s.s; flush = s.f; ext_cycles = s.x;
         #1;
         e = exp_q.pop_front();
         vectors++;
         if (obs !== mk(e, exp_cnt)) begin
            miscompares++;
            $display("FAIL flush row%0d got ph=%b done=%b cnt=%0d want ph=%b done=%b cnt=%0d",
                     k, phase, instr_done, instr_count, e.ph, e.done, exp_cnt);
         end
         tick();
         if (e.done) exp_cnt++;
      end
   endtask

   task automatic test_run_drop();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(0, 0, 0, 0, 4'b0010, 0);
      add(0, 0, 0, 0, 4'b0100, 0);
      add(0, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(1, 0, 0, 0, 4'b0010, 0);
      add(1, 0, 0, 0, 4'b0100, 0);
      add(0, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0000, 0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         s = stim_q.pop_front();
         run = s.r; stall = s.s; flush = s.f; ext_cycles = s.x;
         #1;
         e = exp_q.pop_front();
         vectors++;
         if (obs !== mk(e, exp_cnt)) begin
            miscompares++;
            $display("FAIL run_drop row%0d got ph=%b done=%b cnt=%0d want ph=%b done=%b cnt=%0d",
                     k, phase, instr_done, instr_count, e.ph, e.done, exp_cnt);
         end
         tick();
         if (e.done) exp_cnt++;
      end
   endtask

   task automatic test_async_reset_wrap();
      stim_t s;
      exp_t  e;
      add(1, 0, 0, 0, 4'b0000, 0);
      add(1, 0, 0, 0, 4'b0001, 0);
      add(1, 0, 0, 3, 4'b0010, 0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         s = stim_q.pop_front();
         run = s.r; stall = s.s; flush = s.f; ext_cycles = s.x;
         #1;
         e = exp_q.pop_front();
         vectors++;
         if (obs !== mk(e, exp_cnt)) begin
            miscompares++;
            $display("FAIL pre_reset row%0d got ph=%b cnt=%0d want ph=%b cnt=%0d",
                     k, phase, instr_count, e.ph, exp_cnt);
         end
         tick();
         if (e.done) exp_cnt++;
      end
      ext_cycles = 4'd0;
      #1;
      vectors++;
      if (phase !== 4'b0100) begin
         miscompares++;
         $display("FAIL mid_exec got ph=%b want ph=0100", phase);
      end
      #2;
      reset = 1'b0;
      exp_cnt = '0;
      #1;
      vectors++;
      if (obs !== 40'd0) begin
         miscompares++;
         $display("FAIL async_reset obs=%h want=0", obs);
      end
      run = 1'b0;
      tick();
      reset = 1'b1;
      add(1, 0, 0, 0, 4'b0000, 0);
      for (int j = 0; j < 64; j++)
         add(1, 0, 0, 0, 4'(1 << (j % 4)), (j % 4) == 3);
      add(0, 0, 0, 0, 4'b0001, 0);
      add(0, 0, 0, 0, 4'b0010, 0);
      add(0, 0, 0, 0, 4'b0100, 0);
      add(0, 0, 0, 0, 4'b1000, 1);
      add(0, 0, 0, 0, 4'b0000, 0);
      for (int k = 0; stim_q.size() != 0; k++) begin
         s = stim_q.pop_front();
         run = s.r; stall = s.s; flush = s.f; ext_cycles = s.x;
         #1;
         e = exp_q.pop_front();
         vectors++;
         if (obs !== mk(e, exp_cnt)) begin
            miscompares++;
            $display("FAIL wrap row%0d got ph=%b cnt=%0d cnt4=%0d want ph=%b cnt=%0d cnt4=%0d",
                     k, phase, instr_count, count4, e.ph, exp_cnt, exp_cnt[3:0]);
         end
         tick();
         if (e.done) exp_cnt++;
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      tick();
      test_basic();
      test_exec_ext();
      test_stall();
      test_flush();
      test_run_drop();
      test_async_reset_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instruction_phase_sequencer.md
Name: instruction_phase_sequencer

Overview:
Parametrised successor to the fixed four-phase instruction phase generator. It produces a one-hot phase vector of configurable length (fetch, decode, execute, commit for the default of 4). It adds run/idle control, pipeline stall, flush, a multi-cycle execute hold and a retired-instruction counter. It sits beside the CPU control unit and gates every register-enable that is phase-qualified.

Parameters:
PHASES, 4, number of phases per instruction (>=2); phase 0 = fetch, phase PHASES-1 = commit
EXEC_PHASE, 2, index of the phase that can be extended (0 < EXEC_PHASE < PHASES-1)
CYC_W, 4, width of execute-extension count
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
run  in  1  1 = sequence instructions; 0 = go idle at next instruction boundary
stall  in  1  freeze current phase and extension counter
flush  in  1  abort current instruction, restart at fetch
ext_cycles  in  CYC_W  extra execute cycles requested by decode
phase  out  PHASES  one-hot current phase; all-zero when idle
fetch, decode, execute, commit  out  1  aliases of phase[0], phase[1], phase[EXEC_PHASE], phase[PHASES-1]
busy  out  1  1 when phase != 0
instr_done  out  1  combinational; high in the commit cycle that advances (not stalled, no flush)
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, async): phase=0, state IDLE, wait_cnt=0, instr_count=0. All outputs are low or zero immediately, without waiting for a clock edge.
- States: IDLE (phase=0) and RUN (exactly one phase bit set). Phase index p and wait_cnt are registered.
- IDLE: on a clock with run=1, go to p=0 (fetch) on the next edge. Otherwise stay IDLE. stall and flush are ignored in IDLE.
- RUN, per-edge priority: flush > stall > execute hold > advance.
  - flush=1: p=0 if run=1, else IDLE. wait_cnt=0. instr_count unchanged. Applies in any phase, including commit.
  - stall=1 (no flush): p, wait_cnt and instr_count all hold.
  - p==EXEC_PHASE and wait_cnt!=0: hold p, decrement wait_cnt.
  - Otherwise advance:
    - p<PHASES-1: p=p+1.
    - p==PHASES-1: instr_count++, then p=0 if run=1, else IDLE.
- Execute extension: ext_cycles is sampled only on the edge that moves p from EXEC_PHASE-1 to EXEC_PHASE, and is loaded into wait_cnt. The execute phase therefore lasts ext_cycles+1 unstalled cycles. ext_cycles is ignored at all other times. The maximum extension is 2^CYC_W-1.
- Stall during an extension freezes wait_cnt; no decrement occurs.
- Unstalled instruction period = PHASES + ext_cycles cycles.
- instr_done = commit & ~stall & ~flush. It is never high in IDLE.
- A run deassert mid-instruction does not abort the instruction. The current instruction completes through commit, then the block goes IDLE.
- instr_count wraps from 2^CNT_W-1 to 0 with no flag.
- The phase vector is one-hot or zero at all times. Any other value is a design error and is asserted against in verification.

Test Plan:
1. PHASES=4, reset released, run=1, stall=0, ext_cycles=0 -> phase = 0000, then 0001, 0010, 0100, 1000, 0001, ... instr_done pulses every 4th cycle; instr_count reaches 3 after 12 RUN cycles.
2. ext_cycles=3 presented during decode -> phase 0100 held 4 cycles; instruction period 7; a later ext_cycles change while in execute has no effect.
3. stall=1 for 2 cycles while phase=0010 -> 0010 lasts 3 cycles; stall during commit -> instr_done low, count unchanged until released.
4. flush pulse during execute with wait_cnt=2 -> next cycle phase=0001, wait_cnt=0, instr_count unchanged; flush in commit -> no increment.
5. run dropped while phase=0010 -> sequence completes 0100, 1000, then 0000 with busy=0 and count+1; run reasserted -> 0001 on the next edge.
6. reset driven low mid-execute between clock edges -> phase=0000 and instr_count=0 immediately. With CNT_W=4 and 16 completed instructions -> instr_count wraps to 0.
